mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares a single-ported unified instruction/data memory between the pipeline's fetch stage and its memory stage. A 3-state FSM registers the winning request, drives the memory handshake and returns read data with a one-cycle ready pulse. It emits stall_if/stall_mem to the hazard unit, which folds them into its pipeline-wide stall/flush decisions. Data has priority, with a bounded-burst fairness rule so fetch cannot starve.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_BURST, 4, consecutive data grants allowed while fetch waits (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch read request, held high until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetch read data, registered
d_req  in  1  data access request, held high until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ready  out  1  one-cycle pulse, access complete
d_rdata  out  DATA_W  data read result, registered
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, 1 cycle
stall_if  out  1  if_req && !if_ready
stall_mem  out  1  d_req && !d_ready

Behaviour:
- Reset, asynchronous: state IDLE. All outputs and registers 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata, burst counter.
- Reset mid-transaction abandons the access. mem_req drops immediately and no ready pulse is issued.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE, arbitration each cycle:
  - Only d_req: go to BUSY_D.
  - Only if_req: go to BUSY_IF.
  - Both: go to BUSY_D unless burst_cnt == MAX_D_BURST, in which case go to BUSY_IF.
  - Neither: stay in IDLE.
- On a grant edge, latch the winner's addr, we and wdata into the mem_* registers and set mem_req=1. Fetch grants force mem_we=0.
- BUSY_x: hold mem_* stable until mem_ack. On the mem_ack edge:
  - mem_req goes to 0 and the state returns to IDLE.
  - x_ready pulses 1 for exactly the next cycle.
  - For a read, mem_rdata is captured into x_rdata.
  - Data writes leave d_rdata unchanged.
- Latency: request seen in IDLE at cycle N, mem_req high from N+1, mem_ack at cycle N+k (k>=1), ready high at N+k+1. Minimum 2 cycles.
- Completion-cycle exclusion: in the cycle x_ready=1 the arbiter is in IDLE. That requester's req is ignored, because it is the request just served. The other requester may win that cycle, which gives back-to-back service with no idle cycle.
- Burst counter:
  - Increments (saturating at MAX_D_BURST) on each data grant made while if_req is high.
  - Clears on every fetch grant.
  - Clears on a data grant made while if_req is low.
- mem_ack outside BUSY states is ignored.
- A requester dropping req mid-transaction does not abort. The access completes and the ready pulse still fires.
- stall_if and stall_mem are combinational from the inputs and the registered ready. They are never high in the cycle the matching ready is high.
- No alignment or range checking.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding constants (IDLE=2'd0, BUSY_IF=2'd1, BUSY_D=2'd2);
  - the default widths.
- One natural sub-module: mem_arb_fairness, containing the saturating burst counter and the priority-select logic. The FSM and datapath registers stay in the top module.

Test Plan:
- Fetch read only: if_req=1, if_addr=0x40, mem_ack 1 cycle after mem_req, mem_rdata=0x8C010004 -> mem_addr=0x40, mem_we=0, if_ready pulse at N+2, if_rdata=0x8C010004, stall_if high for cycles N..N+1.
- Data write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mem_ack delayed 3 cycles -> mem_req held 3 cycles with stable mem_* outputs, d_ready pulse once, d_rdata unchanged.
- Simultaneous requests: if_req=d_req=1 in the same cycle -> data served first. Fetch is granted in the d_ready cycle, back-to-back, with no idle cycle between the two mem_req periods.
- Starvation: if_req held high and d_req re-asserted continuously, MAX_D_BURST=4 -> exactly 4 data grants, then a fetch grant, then the counter restarts at 0.
- Async reset during BUSY_D with mem_ack pending -> mem_req=0 immediately, no d_ready, state IDLE. A subsequent if_req is served normally.
- Spurious mem_ack in IDLE and a d_req dropped mid-transaction -> no state change from the ack; the dropped request still completes with one d_ready pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, default widths and burst counter width for the memory port arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int MAX_D_BURST_DEF = 4;
  localparam int BURST_CNT_W     = 4;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_arb_fairness.sv
// mem_arb_fairness: data-priority select with a saturating burst counter so fetch cannot starve
//   clk, rst            clock, async active-high reset
//   idle                arbiter can grant this cycle
//   if_req_eff          fetch request after completion-cycle exclusion
//   d_req_eff           data request after completion-cycle exclusion
//   grant_if, grant_d   one-hot grant, both low when nothing wins
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_BURST = MAX_D_BURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req_eff,
  input  logic d_req_eff,
  output logic grant_if,
  output logic grant_d
);
  localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_D_BURST);
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   burst_full;
  always_comb begin
    burst_full  = burst_cnt_q == MAX_CNT;
    grant_d     = idle && d_req_eff && !(if_req_eff && burst_full);
    grant_if    = idle && if_req_eff && !grant_d;
    // only data grants that overtake a waiting fetch count towards the burst
    burst_cnt_d = grant_if ? '0 :
                  grant_d  ? (if_req_eff ? (burst_full ? burst_cnt_q : burst_cnt_q + 1'b1) : '0) :
                  burst_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_cnt_q <= '0;
    else     burst_cnt_q <= burst_cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data stages
//   clk, rst                                   clock, async active-high reset
//   if_req/if_addr -> if_ready/if_rdata        fetch read port, one-cycle ready pulse
//   d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata  data port, one-cycle ready pulse
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack  memory handshake
//   stall_if, stall_mem                        pending-request stalls for the hazard unit
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_D_BURST = MAX_D_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
);
  arb_state_t        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_if, grant_d;
  logic              if_req_eff, d_req_eff;
  // a requester whose ready is showing is the one just served; its req is stale this cycle
  assign if_req_eff = if_req && !if_ready_q;
  assign d_req_eff  = d_req && !d_ready_q;
  mem_arb_fairness #(.MAX_D_BURST(MAX_D_BURST)) u_fair (
    .clk       (clk),
    .rst       (rst),
    .idle      (state_q == IDLE),
    .if_req_eff(if_req_eff),
    .d_req_eff (d_req_eff),
    .grant_if  (grant_if),
    .grant_d   (grant_d)
  );
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_IF: if (mem_ack) begin
        state_d    = IDLE;
        if_ready_d = 1'b1;
        if_rdata_d = mem_rdata;
      end
      BUSY_D: if (mem_ack) begin
        state_d   = IDLE;
        d_ready_d = 1'b1;
        d_rdata_d = mem_we_q ? d_rdata_q : mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  // mem_req is a pure state decode so an async reset drops it at once
  assign mem_req   = state_q != IDLE;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req && !if_ready_q;
  assign stall_mem = d_req && !d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner sequences, grants and read results scoreboarded
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, d_req, d_we, d_ready;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack, stall_if, stall_mem;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_k = 0;
  logic        force_ack = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [31:0] last_d = '0;
  int          cyc;
  int          pulses;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} gr_t;
  typedef struct {logic is_d; logic [31:0] data;} rd_t;
  typedef struct {bit is_d; bit we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int k;} vec_t;
  gr_t  grant_q[$];
  rd_t  rdy_q[$];
  vec_t vecs[6];
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_if(stall_if), .stall_mem(stall_mem)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic flag(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask
  task automatic wait_ready(input int start, output int c);
    c = start;
    do begin
      @(negedge clk);
      c++;
    end while (!(if_ready || d_ready) && c < start + 30);
    if (!(if_ready || d_ready)) flag("ready_timeout");
  endtask
  // memory model: acks the k-th cycle of a request with rsp_data
  initial begin : resp
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      cnt = mem_req ? cnt + 1 : 0;
      mem_ack = force_ack || (mem_req && cnt == ack_k);
      mem_rdata = rsp_data;
    end
  end
  initial begin : mon
    logic prev;
    gr_t  cur;
    rd_t  r;
    prev = 1'b0;
    cur = '{we: 1'b0, addr: '0, wdata: '0};
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        if (grant_q.size() == 0) flag("grant_unexpected");
        else cur = grant_q.pop_front();
      end
      if (mem_req) begin
        chk("mem_we", mem_we, cur.we);
        chk("mem_addr", mem_addr, cur.addr);
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (if_ready || d_ready) begin
        if (rdy_q.size() == 0) flag("ready_unexpected");
        else begin
          r = rdy_q.pop_front();
          chk("ready_src", d_ready, r.is_d);
          chk("rdata", d_ready ? d_rdata : if_rdata, r.data);
        end
      end
      prev = mem_req;
    end
  end
  initial begin
    vecs[0] = '{is_d: 0, we: 0, addr: 32'h40,  wdata: '0,           rdata: 32'h8C010004, k: 1};
    vecs[1] = '{is_d: 1, we: 1, addr: 32'h100, wdata: 32'hDEADBEEF, rdata: 32'h55555555, k: 3};
    vecs[2] = '{is_d: 1, we: 0, addr: 32'h104, wdata: '0,           rdata: 32'h12345678, k: 1};
    vecs[3] = '{is_d: 1, we: 1, addr: 32'h108, wdata: 32'hCAFEF00D, rdata: 32'h99999999, k: 2};
    vecs[4] = '{is_d: 0, we: 0, addr: 32'h44,  wdata: '0,           rdata: 32'h27BDFFE8, k: 2};
    vecs[5] = '{is_d: 1, we: 0, addr: 32'h0,   wdata: '0,           rdata: 32'hFFFFFFFF, k: 4};
    rst = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    chk("reset_ready", {if_ready, d_ready}, '0);
    chk("reset_rdata", {if_rdata, d_rdata}, '0);
    foreach (vecs[i]) begin
      @(negedge clk);
      ack_k = vecs[i].k;
      rsp_data = vecs[i].rdata;
      if (vecs[i].is_d) begin
        d_req = 1; d_we = vecs[i].we; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      end else begin
        if_req = 1; if_addr = vecs[i].addr;
      end
      grant_q.push_back('{we: vecs[i].is_d && vecs[i].we, addr: vecs[i].addr, wdata: vecs[i].wdata});
      if (vecs[i].is_d && !vecs[i].we) last_d = vecs[i].rdata;
      rdy_q.push_back('{is_d: vecs[i].is_d, data: (vecs[i].is_d && vecs[i].we) ? last_d : vecs[i].rdata});
      #1 chk($sformatf("vec%0d_stall_req", i), vecs[i].is_d ? stall_mem : stall_if, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_mem_req", i), mem_req, 1);
      chk($sformatf("vec%0d_stall_wait", i), vecs[i].is_d ? stall_mem : stall_if, 1);
      wait_ready(1, cyc);
      chk($sformatf("vec%0d_latency", i), cyc, vecs[i].k + 1);
      chk($sformatf("vec%0d_who", i), d_ready, vecs[i].is_d);
      chk($sformatf("vec%0d_stall_done", i), vecs[i].is_d ? stall_mem : stall_if, 0);
      if_req = 0; d_req = 0;
    end
    // simultaneous requests: data first, fetch granted in the d_ready cycle
    @(negedge clk);
    ack_k = 1; rsp_data = 32'h11112222;
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h0BADCAFE;
    grant_q.push_back('{we: 1, addr: 32'h300, wdata: 32'h0BADCAFE});
    grant_q.push_back('{we: 0, addr: 32'h200, wdata: '0});
    rdy_q.push_back('{is_d: 1, data: last_d});
    rdy_q.push_back('{is_d: 0, data: 32'h11112222});
    wait_ready(0, cyc);
    chk("simul_data_first", d_ready, 1);
    d_req = 0;
    @(negedge clk);
    chk("simul_b2b_req", mem_req, 1);
    chk("simul_b2b_addr", mem_addr, 32'h200);
    wait_ready(1, cyc);
    chk("simul_fetch_done", if_ready, 1);
    if_req = 0;
    // starvation: both arrive together each round; every fifth grant goes to fetch
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ack_k = 1; rsp_data = 32'hA0000000 + i;
      if_req = 1; if_addr = 32'h1000 + i * 4;
      d_req = 1; d_we = 0; d_addr = 32'h2000 + i * 4;
      grant_q.push_back('{we: 0, addr: (i % 5 != 4) ? d_addr : if_addr, wdata: '0});
      if (i % 5 != 4) last_d = rsp_data;
      rdy_q.push_back('{is_d: i % 5 != 4, data: rsp_data});
      wait_ready(0, cyc);
      chk($sformatf("burst%0d_winner", i), d_ready, i % 5 != 4);
      if_req = 0; d_req = 0;
      @(negedge clk);
    end
    // async reset while a data read waits for its ack
    @(negedge clk);
    ack_k = 10;
    d_req = 1; d_we = 0; d_addr = 32'h500;
    grant_q.push_back('{we: 0, addr: 32'h500, wdata: '0});
    repeat (2) @(negedge clk);
    chk("rst_busy", mem_req, 1);
    #3 rst = 1'b1;
    #1 chk("rst_async_drop", mem_req, 0);
    chk("rst_no_ready", {if_ready, d_ready}, '0);
    d_req = 0;
    @(negedge clk);
    rst = 1'b0;
    last_d = '0;
    chk("rst_rdata_clear", d_rdata, 0);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(d_ready);
    end
    chk("rst_ready_absent", pulses, 0);
    @(negedge clk);
    ack_k = 1; rsp_data = 32'h600DF00D;
    if_req = 1; if_addr = 32'h600;
    grant_q.push_back('{we: 0, addr: 32'h600, wdata: '0});
    rdy_q.push_back('{is_d: 0, data: 32'h600DF00D});
    wait_ready(0, cyc);
    chk("post_rst_fetch_lat", cyc, 2);
    if_req = 0;
    // spurious ack while idle, then a data read whose req drops mid-access
    ack_k = 0;
    @(posedge clk);
    force_ack = 1'b1;
    @(posedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("spur_idle", {mem_req, if_ready, d_ready}, '0);
    ack_k = 3; rsp_data = 32'h7777AAAA;
    d_req = 1; d_we = 0; d_addr = 32'h700;
    grant_q.push_back('{we: 0, addr: 32'h700, wdata: '0});
    rdy_q.push_back('{is_d: 1, data: 32'h7777AAAA});
    last_d = 32'h7777AAAA;
    @(negedge clk);
    chk("drop_busy", mem_req, 1);
    d_req = 0;
    wait_ready(1, cyc);
    chk("drop_latency", cyc, 4);
    chk("drop_ready", d_ready, 1);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(d_ready) + int'(mem_req);
    end
    chk("drop_single_pulse", pulses, 0);
    chk("grant_q_drained", grant_q.size(), 0);
    chk("rdy_q_drained", rdy_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
